// File: rtl/fp_wb_if.sv
// Bus bundle between the FPU intermediate-result producers, the write-back
// arbiter and the normalize/round stage.
interface fp_wb_if #(
    parameter int NUM_WB_UNITS = 4,
    parameter int ID_W         = 3,
    parameter int PAYLOAD_W    = 76,
    parameter int UNIT_W       = 2
);
    logic [NUM_WB_UNITS-1:0]                unit_done;
    logic [NUM_WB_UNITS-1:0][ID_W-1:0]      unit_id;
    logic [NUM_WB_UNITS-1:0][PAYLOAD_W-1:0] unit_payload;
    logic [NUM_WB_UNITS-1:0]                unit_ack;
    logic                                   out_valid;
    logic                                   out_ready;
    logic [ID_W-1:0]                        out_id;
    logic [PAYLOAD_W-1:0]                   out_payload;
    logic [UNIT_W-1:0]                      out_unit;

    // Arbiter view.
    modport slave (
        input  unit_done, unit_id, unit_payload, out_ready,
        output unit_ack, out_valid, out_id, out_payload, out_unit
    );

    // Producer / normalize-stage view.
    modport master (
        output unit_done, unit_id, unit_payload, out_ready,
        input  unit_ack, out_valid, out_id, out_payload, out_unit
    );
endinterface

// File: rtl/fp_wb_arbiter.sv
// Round-robin arbiter collecting unnormalized FPU results into one registered
// output slot. Define FP_WB_FIXED_PRIORITY_EN for lowest-index-wins priority.
module fp_wb_arbiter #(
    parameter int NUM_WB_UNITS = 4,
    parameter int ID_W         = 3,
    parameter int PAYLOAD_W    = 76,
    parameter int UNIT_W       = 2
) (
    input  logic  clk,
    input  logic  rst,
    fp_wb_if.slave bus
);

    logic                    can_load_s;
    logic                    grant_vld_s;
    logic                    load_s;
    logic [UNIT_W-1:0]       grant_idx_s;
    logic [UNIT_W-1:0]       cand_s;
    logic [NUM_WB_UNITS-1:0] ack_s;

    logic                    out_valid_d, out_valid_q;
    logic [ID_W-1:0]         out_id_d, out_id_q;
    logic [PAYLOAD_W-1:0]    out_payload_d, out_payload_q;
    logic [UNIT_W-1:0]       out_unit_d, out_unit_q;

`ifndef FP_WB_FIXED_PRIORITY_EN
    logic [UNIT_W-1:0]       rr_ptr_d, rr_ptr_q;
`endif

    assign can_load_s = ~out_valid_q | bus.out_ready;
    assign load_s     = can_load_s & grant_vld_s;

    // Grant search: walk candidates from last to first so the first hit wins.
    always_comb begin
        int sum_v;
        grant_vld_s = 1'b0;
        grant_idx_s = {UNIT_W{1'b0}};
        cand_s      = {UNIT_W{1'b0}};
        sum_v       = 0;
        for (int k = NUM_WB_UNITS - 1; k >= 0; k--) begin
`ifdef FP_WB_FIXED_PRIORITY_EN
            sum_v  = k;
`else
            sum_v  = int'(rr_ptr_q) + k;
            sum_v  = (sum_v >= NUM_WB_UNITS) ? (sum_v - NUM_WB_UNITS) : sum_v;
`endif
            cand_s      = UNIT_W'(sum_v);
            grant_idx_s = bus.unit_done[cand_s] ? cand_s : grant_idx_s;
            grant_vld_s = grant_vld_s | bus.unit_done[cand_s];
        end
    end

    // One-hot acknowledge in the same cycle the winner is captured.
    always_comb begin
        ack_s = {NUM_WB_UNITS{1'b0}};
        for (int i = 0; i < NUM_WB_UNITS; i++) begin
            ack_s[i] = load_s & ~rst & (grant_idx_s == UNIT_W'(i));
        end
    end

    assign bus.unit_ack = ack_s;

    // Output slot next state: load (also covers drain+load), drain, or hold.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_id_d      = out_id_q;
        out_payload_d = out_payload_q;
        out_unit_d    = out_unit_q;
        if (load_s) begin
            out_valid_d   = 1'b1;
            out_id_d      = bus.unit_id[grant_idx_s];
            out_payload_d = bus.unit_payload[grant_idx_s];
            out_unit_d    = grant_idx_s;
        end else if (out_valid_q & bus.out_ready) begin
            out_valid_d   = 1'b0;
        end else begin
            out_valid_d   = out_valid_q;
        end
    end

`ifndef FP_WB_FIXED_PRIORITY_EN
    // Pointer moves past the winner only when a result is actually taken.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (load_s) begin
            rr_ptr_d = (grant_idx_s == UNIT_W'(NUM_WB_UNITS - 1)) ? {UNIT_W{1'b0}}
                                                                  : grant_idx_s + UNIT_W'(1'b1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= {UNIT_W{1'b0}};
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Output slot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_id_q      <= {ID_W{1'b0}};
            out_payload_q <= {PAYLOAD_W{1'b0}};
            out_unit_q    <= {UNIT_W{1'b0}};
        end else begin
            out_valid_q   <= out_valid_d;
            out_id_q      <= out_id_d;
            out_payload_q <= out_payload_d;
            out_unit_q    <= out_unit_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_id      = out_id_q;
    assign bus.out_payload = out_payload_q;
    assign bus.out_unit    = out_unit_q;

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Table-driven bench for fp_wb_arbiter with a scoreboard of expected results.
module tb_fp_wb_arbiter;

    localparam int N  = 4;
    localparam int IW = 3;
    localparam int PW = 76;
    localparam int UW = 2;

    typedef struct {
        logic         rst;
        logic [N-1:0] done;
        logic         rdy;
        logic [N-1:0] ack;
        logic         vld;
    } vec_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [PW-1:0] payload;
        logic [UW-1:0] unit;
    } rec_t;

    logic   clk;
    logic   rst;
    vec_t   tbl[$];
    rec_t   sb[$];
    rec_t   last;
    rec_t   rec;
    int     gen[N];
    int     pass_cnt;
    int     total_cnt;

    fp_wb_if #(.NUM_WB_UNITS(N), .ID_W(IW), .PAYLOAD_W(PW), .UNIT_W(UW)) bus ();

    fp_wb_arbiter #(.NUM_WB_UNITS(N), .ID_W(IW), .PAYLOAD_W(PW), .UNIT_W(UW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [IW-1:0] id_of(input int i, input int g);
        return IW'((4 + i + 4 * g) % 8);
    endfunction

    function automatic logic [PW-1:0] pl_of(input int i, input int g);
        return {4'(i), 8'(g), 64'h0123_4567_89AB_CDEF ^ 64'(g)};
    endfunction

    task automatic add(input logic r, input logic [N-1:0] d, input logic rd,
                       input logic [N-1:0] a, input logic v);
        vec_t t;
        t.rst = r; t.done = d; t.rdy = rd; t.ack = a; t.vld = v;
        tbl.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst = 1'b1;
        bus.unit_done    = '0;
        bus.unit_id      = '0;
        bus.unit_payload = '0;
        bus.out_ready    = 1'b0;
        for (int i = 0; i < N; i++) gen[i] = 0;
        last = '{id: '0, payload: '0, unit: '0};

        //   rst   done     rdy   ack      vld
        add(1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0);
        add(1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0);
`ifdef FP_WB_FIXED_PRIORITY_EN
        add(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1);
        add(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1);
        add(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1);
        add(1'b0, 4'b1110, 1'b1, 4'b0010, 1'b1);
        add(1'b0, 4'b1100, 1'b1, 4'b0100, 1'b1);
        add(1'b0, 4'b1000, 1'b0, 4'b0000, 1'b1);
        add(1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1);
        add(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
`else
        add(1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1);  // single producer, id 5
        add(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);  // drain, ptr stays at 2
        add(1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1);
        add(1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1);
        add(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1);
        add(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1);
        add(1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1);
        add(1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1);
        add(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1);
        add(1'b0, 4'b1000, 1'b0, 4'b0000, 1'b1);  // stall x3
        add(1'b0, 4'b1000, 1'b0, 4'b0000, 1'b1);
        add(1'b0, 4'b1000, 1'b0, 4'b0000, 1'b1);
        add(1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1);  // ready rises
        add(1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1);  // ptr -> 3
        add(1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1);  // unit 3 wins, ptr wraps
        add(1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1);
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
        add(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
        add(1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1);  // empty slot loads without ready
        add(1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1);
        add(1'b1, 4'b0100, 1'b1, 4'b0000, 1'b0);  // reset mid-operation
        add(1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1);
        add(1'b0, 4'b0011, 1'b1, 4'b0001, 1'b1);
        add(1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1);
        add(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
`endif

        for (int s = 0; s < tbl.size(); s++) begin
            @(negedge clk);
            rst           = tbl[s].rst;
            bus.out_ready = tbl[s].rdy;
            bus.unit_done = tbl[s].done;
            for (int i = 0; i < N; i++) begin
                bus.unit_id[i]      = id_of(i, gen[i]);
                bus.unit_payload[i] = pl_of(i, gen[i]);
            end
            #1;
            chk($sformatf("ack[%0d]", s), 128'(bus.unit_ack), 128'(tbl[s].ack));
            if (tbl[s].ack != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (tbl[s].ack[i]) begin
                        rec.id      = id_of(i, gen[i]);
                        rec.payload = pl_of(i, gen[i]);
                        rec.unit    = UW'(i);
                    end
                end
                sb.push_back(rec);
            end
            @(posedge clk);
            #1;
            chk($sformatf("valid[%0d]", s), 128'(bus.out_valid), 128'(tbl[s].vld));
            if (tbl[s].rst) begin
                chk($sformatf("rst_id[%0d]", s), 128'(bus.out_id), 128'(0));
                chk($sformatf("rst_pl[%0d]", s), 128'(bus.out_payload), 128'(0));
                chk($sformatf("rst_unit[%0d]", s), 128'(bus.out_unit), 128'(0));
            end else if (tbl[s].ack != '0) begin
                if (sb.size() == 0) begin
                    chk($sformatf("sb_empty[%0d]", s), 128'(1), 128'(0));
                end else begin
                    last = sb.pop_front();
                    chk($sformatf("id[%0d]", s), 128'(bus.out_id), 128'(last.id));
                    chk($sformatf("pl[%0d]", s), 128'(bus.out_payload), 128'(last.payload));
                    chk($sformatf("unit[%0d]", s), 128'(bus.out_unit), 128'(last.unit));
                end
            end else if (tbl[s].vld) begin
                chk($sformatf("hold_id[%0d]", s), 128'(bus.out_id), 128'(last.id));
                chk($sformatf("hold_pl[%0d]", s), 128'(bus.out_payload), 128'(last.payload));
                chk($sformatf("hold_unit[%0d]", s), 128'(bus.out_unit), 128'(last.unit));
            end else begin
                chk($sformatf("idle_ack[%0d]", s), 128'(bus.unit_ack), 128'(0));
            end
            for (int i = 0; i < N; i++) begin
                if (tbl[s].ack[i]) gen[i] = gen[i] + 1;
            end
        end

        chk("sb_drained", 128'(sb.size()), 128'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
